// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID/EX pipeline registers and the forwarding/hazard unit.
// Signal names follow the pipeline nets they carry.
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5,
   parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
   logic                       flush;
   logic [NUM_SRC*REG_AW-1:0]  ex_rs;
   logic [NUM_FWD-1:0]         fwd_we;
   logic [NUM_FWD*REG_AW-1:0]  fwd_rd;
   logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
   logic [NUM_SRC*REG_AW-1:0]  id_rs;
   logic [NUM_SRC-1:0]         id_rs_used;
   logic [REG_AW-1:0]          id_rd;
   logic                       id_long_issue;
   logic                       ex_is_load;
   logic                       ex_we;
   logic [REG_AW-1:0]          ex_rd;
   logic                       long_wb_valid;
   logic [REG_AW-1:0]          long_wb_rd;
   logic                       stall;
   logic                       bubble;
   logic [1:0]                 stall_cause;
   logic                       sb_busy;

   modport master (
      output flush, ex_rs, fwd_we, fwd_rd, id_rs, id_rs_used, id_rd,
             id_long_issue, ex_is_load, ex_we, ex_rd, long_wb_valid, long_wb_rd,
      input  fwd_sel, stall, bubble, stall_cause, sb_busy
   );

   modport slave (
      input  flush, ex_rs, fwd_we, fwd_rd, id_rs, id_rs_used, id_rd,
             id_long_issue, ex_is_load, ex_we, ex_rd, long_wb_valid, long_wb_rd,
      output fwd_sel, stall, bubble, stall_cause, sb_busy
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use and multi-cycle scoreboard hazard control.
// Forwarding is purely combinational; stall state lives in a load counter and pending bits.
module fwd_hazard_unit #(
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 2,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
   input logic               clk,
   input logic               rst_n,
   fwd_hazard_unit_if.slave  io_hz
);
   localparam int NUM_REG = 1 << REG_AW;
   localparam int CNT_W   = $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

   logic [CNT_W-1:0]          r_load_cnt;
   logic [NUM_REG-1:0]        r_pending;
   logic [NUM_REG-1:0]        w_pending_nxt;
   logic [NUM_SRC*SEL_W-1:0]  w_fwd_sel;
   logic                      w_ld_hit;
   logic                      w_ld_stall;
   logic                      w_sb_hit;
   logic                      w_hazard;
   logic                      w_issue_ok;
   logic                      w_out_en;

   // Scan oldest to youngest so the youngest matching stage is written last and wins.
   always_comb begin : fwd_select
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
      w_fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (io_hz.fwd_we[i] &&
                io_hz.fwd_rd[i*REG_AW +: REG_AW] != '0 &&
                io_hz.fwd_rd[i*REG_AW +: REG_AW] == io_hz.ex_rs[s*REG_AW +: REG_AW]) begin
               w_fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(NUM_FWD - i);
            end
         end
      end
   end

   always_comb begin : load_use_detect
      w_ld_hit = 1'b0;
      if (io_hz.ex_is_load && io_hz.ex_we && io_hz.ex_rd != '0) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (io_hz.id_rs_used[s] && io_hz.id_rs[s*REG_AW +: REG_AW] == io_hz.ex_rd) begin
               w_ld_hit = 1'b1;
            end
         end
      end
   end

   assign w_ld_stall = w_ld_hit || (r_load_cnt != '0);

   always_comb begin : scoreboard_detect
      w_sb_hit = io_hz.id_long_issue && r_pending[io_hz.id_rd];
      for (int s = 0; s < NUM_SRC; s++) begin
         if (io_hz.id_rs_used[s] && r_pending[io_hz.id_rs[s*REG_AW +: REG_AW]]) begin
            w_sb_hit = 1'b1;
         end
      end
   end

   assign w_hazard   = w_ld_stall || w_sb_hit;
   assign w_issue_ok = io_hz.id_long_issue && !w_hazard && !io_hz.flush && (io_hz.id_rd != '0);

   // Issue is applied after writeback so a same-cycle set on the same register wins.
   always_comb begin : pending_next
      w_pending_nxt = r_pending;
      if (io_hz.long_wb_valid) begin
         w_pending_nxt[io_hz.long_wb_rd] = 1'b0;
      end
      if (w_issue_ok) begin
         w_pending_nxt[io_hz.id_rd] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin : load_counter
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_load_cnt <= '0;
      end else if (io_hz.flush) begin
         r_load_cnt <= '0;
      end else if (w_ld_hit) begin
         r_load_cnt <= CNT_LOAD;
      end else if (r_load_cnt != '0) begin
         r_load_cnt <= r_load_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin : scoreboard_reg
      // NOTE: the pending array is flops, not RAM; it must reset or stale bits would stall after reset.
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign w_out_en          = rst_n && !io_hz.flush;
   assign io_hz.fwd_sel     = rst_n ? w_fwd_sel : '0;
   assign io_hz.stall       = w_out_en && w_hazard;
   assign io_hz.bubble      = w_out_en && w_hazard;
   assign io_hz.stall_cause = w_out_en ? {w_sb_hit, w_ld_stall} : 2'b00;
   assign io_hz.sb_busy     = rst_n && (|r_pending);
endmodule
